delay_scheduler: RTL and testbench
==================================

# delay_scheduler

Time-shares one down-counter among N_REQ requesters. Each requester asks for a delay of a programmable number of clock cycles. Requests are granted in round-robin order, and each requester receives a one-cycle done pulse when its delay expires. The block sits between FSMs that need occasional waits (settle, debounce, power-up spacing) and replaces per-client delay timers with a single counter.

## Interface
- N_REQ, 4, number of requesters (2..16)
- CNT_W, 16, width of each delay request in cycles
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  level request per requester; held high until its done pulse
- delay_cycles  in  N_REQ*CNT_W  requester i's delay in bits [i*CNT_W +: CNT_W]; sampled only at grant
- grant  out  N_REQ  one-hot; high while requester owns the counter
- done  out  N_REQ  one-cycle pulse to the owner when its delay expires
- busy  out  1  high whenever any grant is high
- active_id  out  $clog2(N_REQ)  index of current owner; 0 when idle

## Operation
- Reset values:
  - state IDLE, grant 0, done 0, busy 0, active_id 0
  - counter 0, round-robin pointer 0
- States:
  - IDLE: if any req is high, pick the winner: first set req bit at index ≥ pointer, wrapping modulo N_REQ. Load counter with delay_cycles[winner], set grant[winner], busy and active_id, then go to RUN. If no req is high, stay in IDLE.
  - RUN, owner req still high: if counter > 1, decrement; else set done[owner] and go to DONE.
  - RUN, owner req dropped (abort): clear grant, busy, active_id and counter; no done pulse; go to IDLE; pointer becomes owner+1.
  - DONE: clear done, grant, busy and active_id; pointer becomes owner+1 mod N_REQ; go to IDLE.
- Delay of 0 is treated as 1.
- Only the owner's req and delay are observed during RUN. Changes to other requesters' inputs have no effect until the next arbitration.
- A req still high in the IDLE cycle after its done pulse is a new request and arbitrates normally.
- Counter is CNT_W bits, never wraps, and never decrements below 1.

## Timing
- Let E0 be the edge on which IDLE arbitrates and grant rises. done[owner] is high for exactly the cycle following edge E0 + max(D,1).
- grant falls on the edge after done rises, so grant overlaps done for one cycle.
- Minimum turnaround between consecutive grants is one IDLE cycle. The next grant can rise at the earliest at E0 + max(D,1) + 2.
- Abort: grant falls on the first edge that samples the owner's req low.
- rst mid-operation: on the next edge all outputs, the pointer and the counter return to reset values. An in-flight delay produces no done pulse.
- done is never high for a requester that does not hold grant in the same cycle.

## Structure
- Shared package delay_sched_pkg:
  - state enum: IDLE, RUN, DONE
  - function id_width(n) returning max(1, $clog2(n))
- One sub-module, rr_arbiter: takes the req vector and the pointer, returns the one-hot winner and its index.
  - Purely combinational.
  - The pointer register lives in delay_scheduler.

## Test plan
- Single request: N_REQ=4, req[2]=1 with delay 5 at E0 → grant=4'b0100 and active_id=2 from E0; done[2] high one cycle after E0+5; grant low after E0+6; busy tracks grant.
- Zero and one delay: delay 0 and delay 1 on req[0] → done[0] one cycle after E0+1 in both cases.
- Round-robin fairness: req=4'b1111 held, all delays 2 → grant order 0,1,2,3,0; each requester granted once per four grants; one IDLE cycle between grants.
- Abort: req[1] delay 10, drop req[1] at E0+4 → no done pulse; grant clears next edge; pointer advances so pending req[3] is granted before req[0].
- Reset mid-run: req[3] delay 20, rst high at E0+7 → next edge all outputs 0; no done; after release a pending req[0] wins first (pointer 0).
- Max width: CNT_W=4, delay 15 → done one cycle after E0+15; counter never wraps or underflows.

Source files
------------

// File: rtl/delay_sched_pkg.sv
// Shared types and helpers for the time-shared delay counter.
package delay_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for n requesters. Stays at least 1 bit so that N_REQ=1-style
    // corner cases never produce a zero-width vector.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/delay_scheduler_if.sv
// Requester-side bundle: level requests with per-requester delays, grant/done back.
interface delay_scheduler_if
    import delay_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
);
    logic [N_REQ-1:0]           req;
    logic [N_REQ*CNT_W-1:0]     delay_cycles;
    logic [N_REQ-1:0]           grant;
    logic [N_REQ-1:0]           done;
    logic                       busy;
    logic [id_width(N_REQ)-1:0] active_id;

    modport master (
        output req, delay_cycles,
        input  grant, done, busy, active_id
    );

    modport slave (
        input  req, delay_cycles,
        output grant, done, busy, active_id
    );
endinterface

// File: rtl/delay_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req at index >= ptr, wrapping.
module rr_arbiter
    import delay_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] win_o,
    output logic [IW-1:0]    win_idx_o,
    output logic             vld_o
);

    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        found     = 1'b0;
        idx       = '0;
        win_idx_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = IW'((int'(ptr_i) + i) % N_REQ);
            if (!found && req_i[idx]) begin
                found     = 1'b1;
                win_idx_o = idx;
            end
        end
        vld_o = found;
        win_o = found ? (N_REQ'(1) << win_idx_o) : '0;
    end

endmodule

// File: rtl/delay_scheduler.sv
// One shared down-counter handed out round-robin; owner gets a done pulse on expiry.
module delay_scheduler
    import delay_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    delay_scheduler_if.slave   bus
);

    localparam int IW = id_width(N_REQ);

    state_t             state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [N_REQ-1:0]   own_oh_q, own_oh_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_REQ-1:0]   win;
    logic [IW-1:0]      win_idx;
    logic               win_vld;
    logic [CNT_W-1:0]   win_dly;
    logic [IW-1:0]      owner_nxt;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i     (bus.req),
        .ptr_i     (ptr_q),
        .win_o     (win),
        .win_idx_o (win_idx),
        .vld_o     (win_vld)
    );

    assign win_dly   = bus.delay_cycles[win_idx*CNT_W +: CNT_W];
    assign owner_nxt = (owner_q == IW'(N_REQ-1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            own_oh_q <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            own_oh_q <= own_oh_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        own_oh_d = own_oh_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (win_vld) begin
                state_d  = RUN;
                owner_d  = win_idx;
                own_oh_d = win;
                // A zero delay still costs one cycle, same as a delay of one.
                cnt_d    = (win_dly == '0) ? CNT_W'(1) : win_dly;
            end
            RUN: begin
                if (!bus.req[owner_q]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ptr_d   = owner_nxt;
                end else if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = owner_nxt;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are pure functions of registered state, so done can only ever
    // appear alongside the owner's grant.
    always_comb begin
        bus.grant     = '0;
        bus.done      = '0;
        bus.busy      = 1'b0;
        bus.active_id = '0;
        if (state_q != IDLE) begin
            bus.grant     = own_oh_q;
            bus.busy      = 1'b1;
            bus.active_id = owner_q;
        end
        if (state_q == DONE) bus.done = own_oh_q;
    end

endmodule

// File: tb/tb_delay_scheduler.sv
// Directed bench: table of per-cycle vectors plus hand sequences for abort, reset and max width.
module tb_delay_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    delay_scheduler_if #(.N_REQ(4), .CNT_W(16)) bus ();
    delay_scheduler_if #(.N_REQ(4), .CNT_W(4))  busw ();

    delay_scheduler #(.N_REQ(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    delay_scheduler #(.N_REQ(4), .CNT_W(4)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (busw.slave)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [63:0] dly;
        logic [3:0]  grant;
        logic [3:0]  done;
        logic        busy;
        logic [1:0]  id;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [63:0] dl,
                       input logic [3:0] g, input logic [3:0] d, input logic b,
                       input logic [1:0] id);
        vec_t v;
        v.rst = r; v.req = rq; v.dly = dl;
        v.grant = g; v.done = d; v.busy = b; v.id = id;
        vecs.push_back(v);
    endtask

    task automatic chk_out(input string nm, input logic [3:0] g, input logic [3:0] d,
                           input logic b, input logic [1:0] id);
        chk({nm, ".grant"}, 32'(bus.grant), 32'(g));
        chk({nm, ".done"},  32'(bus.done),  32'(d));
        chk({nm, ".busy"},  32'(bus.busy),  32'(b));
        chk({nm, ".id"},    32'(bus.active_id), 32'(id));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] D_S5 = {16'd0, 16'd5, 16'd0, 16'd0};
    localparam logic [63:0] D_Z  = 64'd0;
    localparam logic [63:0] D_1  = {16'd0, 16'd0, 16'd0, 16'd1};
    localparam logic [63:0] D_RR = {16'd2, 16'd2, 16'd2, 16'd2};

    initial begin
        int rr_order[5];
        logic [3:0] g;
        rr_order = '{0, 1, 2, 3, 0};

        bus.req = '0;  bus.delay_cycles = '0;
        busw.req = '0; busw.delay_cycles = '0;

        // Reset, then req[2] with delay 5: done after E0+5, grant drops at E0+6
        add(1, 4'b0000, D_Z,  4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0100, D_S5, 4'b0100, 4'b0000, 1, 2);
        for (int i = 0; i < 4; i++) add(0, 4'b0100, D_S5, 4'b0100, 4'b0000, 1, 2);
        add(0, 4'b0100, D_S5, 4'b0100, 4'b0100, 1, 2);
        add(0, 4'b0100, D_S5, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0000, D_S5, 4'b0000, 4'b0000, 0, 0);
        // Delay 0 and delay 1 on req[0] both finish after E0+1
        add(0, 4'b0001, D_Z,  4'b0001, 4'b0000, 1, 0);
        add(0, 4'b0001, D_Z,  4'b0001, 4'b0001, 1, 0);
        add(0, 4'b0000, D_Z,  4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0001, D_1,  4'b0001, 4'b0000, 1, 0);
        add(0, 4'b0001, D_1,  4'b0001, 4'b0001, 1, 0);
        add(0, 4'b0000, D_1,  4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0000, D_1,  4'b0000, 4'b0000, 0, 0);
        // Reset dominates held requests, then round robin 0,1,2,3,0 with delay 2
        add(1, 4'b1111, D_RR, 4'b0000, 4'b0000, 0, 0);
        foreach (rr_order[k]) begin
            g = 4'b0001 << rr_order[k];
            add(0, 4'b1111, D_RR, g, 4'b0000, 1, 2'(rr_order[k]));
            add(0, 4'b1111, D_RR, g, 4'b0000, 1, 2'(rr_order[k]));
            add(0, 4'b1111, D_RR, g, g,       1, 2'(rr_order[k]));
            add(0, 4'b1111, D_RR, 4'b0000, 4'b0000, 0, 0);
        end

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            bus.req = vecs[i].req;
            bus.delay_cycles = vecs[i].dly;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].done, vecs[i].busy, vecs[i].id);
        end

        // Abort: req[1] delay 10 dropped so edge E0+4 samples it low; req[3] beats req[0]
        rst = 1'b1; bus.req = '0; step();
        rst = 1'b0;
        bus.delay_cycles = {16'd3, 16'd0, 16'd10, 16'd3};
        bus.req = 4'b0010; step();
        chk_out("abort.e0", 4'b0010, 4'b0000, 1, 1);
        bus.req = 4'b1011;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_out($sformatf("abort.run%0d", i), 4'b0010, 4'b0000, 1, 1);
        end
        bus.req = 4'b1001; step();
        chk_out("abort.drop", 4'b0000, 4'b0000, 0, 0);
        step();
        chk_out("abort.next", 4'b1000, 4'b0000, 1, 3);
        bus.req = '0; step(); step();

        // Reset mid-run: req[3] delay 20, rst after E0+7; pointer back to 0 so req[0] wins
        rst = 1'b1; step();
        rst = 1'b0;
        bus.delay_cycles = {16'd20, 16'd0, 16'd0, 16'd4};
        bus.req = 4'b1000; step();
        chk_out("rst.e0", 4'b1000, 4'b0000, 1, 3);
        bus.req = 4'b1001;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk_out($sformatf("rst.run%0d", i), 4'b1000, 4'b0000, 1, 3);
        end
        rst = 1'b1; step();
        chk_out("rst.mid", 4'b0000, 4'b0000, 0, 0);
        rst = 1'b0; step();
        chk_out("rst.after", 4'b0001, 4'b0000, 1, 0);
        bus.req = '0; step(); step();

        // Max width on the 4-bit counter instance: delay 15 finishes after E0+15
        busw.delay_cycles = {4'd0, 4'd0, 4'd0, 4'hF};
        busw.req = 4'b0001; step();
        chk("wide.e0.grant", 32'(busw.grant), 32'h1);
        for (int i = 1; i <= 14; i++) begin
            step();
            chk($sformatf("wide.run%0d.done", i), 32'(busw.done), 32'h0);
            chk($sformatf("wide.run%0d.grant", i), 32'(busw.grant), 32'h1);
        end
        step();
        chk("wide.e15.done", 32'(busw.done), 32'h1);
        busw.req = '0; step();
        chk("wide.e16.grant", 32'(busw.grant), 32'h0);
        chk("wide.e16.done",  32'(busw.done),  32'h0);
        step();
        chk("wide.idle.busy", 32'(busw.busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
